// File: rtl/d_cache_control_pkg.sv
// Shared types for the L1 data cache controller: FSM state encoding and address geometry.
// No logic; no latency; no backpressure.
// 2-way, 8-set, 16-byte-line cache: address = {tag[15:7], index[6:4], offset[3:0]}.
package d_cache_control_pkg;

  localparam int C_OFFSET_BITS = 4;
  localparam int C_INDEX_BITS  = 3;
  localparam int C_TAG_BITS    = 9;

  typedef logic [C_TAG_BITS+C_INDEX_BITS-1:0] lc3b_c_line_addr;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } d_cache_state_t;

  // Line-aligned byte address for a 12-bit line number.
  function automatic logic [15:0] line_to_addr(input lc3b_c_line_addr line);
    return {line, {C_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/d_cache_control_if.sv
// CPU-side and pmem-side request/response bundle of the data cache controller.
// No logic; no latency; requests are held by the requester until the matching resp pulse.
// slave = controller view, master = CPU + memory environment view.
interface d_cache_control_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic        pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_address, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_address
  );

  modport master (
    output mem_read, mem_write, mem_address, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_address
  );
endinterface

// File: rtl/d_cache_control_perf_counters.sv
// Saturating hit/miss/writeback event counters, used only under D_CACHE_PERF_CNT_EN.
// Latency: count visible the cycle after the event; no backpressure (events never stall).
// perf_clr is synchronous and wins over a same-cycle increment.
module d_cache_perf_counters #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 perf_clr,
  input  logic                 hit_evt,
  input  logic                 miss_evt,
  input  logic                 wb_evt,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else if (perf_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      hit_count  <= sat_inc(hit_count, hit_evt);
      miss_count <= sat_inc(miss_count, miss_evt);
      wb_count   <= sat_inc(wb_count, wb_evt);
    end
  end

endmodule

// File: rtl/d_cache_control.sv
// Sequencing FSM for the 2-way write-back L1 D-cache: hit service, dirty writeback, line allocate.
// Latency: read/write hit resp 2nd cycle after request; miss adds pmem round trip(s). D_CACHE_PERF_CNT_EN adds counters.
// Backpressure: blocking, one outstanding CPU request; pmem requests held until pmem_resp.
module d_cache_control
  import d_cache_control_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  d_cache_control_if.slave      bus,
  input  logic                  hit,
  input  logic                  curr_way,
  input  logic                  lru_out,
  input  logic                  dirty0_out,
  input  logic                  dirty1_out,
  input  logic [C_TAG_BITS-1:0] pmem_tag,
  output logic                  ld_cache,
  output logic                  ld_lru,
  output logic                  ld_dirty0,
  output logic                  ld_dirty1,
  output logic                  dirty0_in,
  output logic                  dirty1_in,
  output logic                  writecachemux_sel,
  output logic                  data0mux_sel,
  output logic                  data1mux_sel,
  output logic                  ld_from_vic
`ifdef D_CACHE_PERF_CNT_EN
  ,
  input  logic                  perf_clr,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [CNT_WIDTH-1:0]  wb_count
`endif
);

  d_cache_state_t  state;
  logic            req;
  logic            is_write;
  logic            victim_dirty;
  lc3b_c_line_addr victim_line;
  lc3b_c_line_addr req_line;

  assign req          = bus.mem_read | bus.mem_write;
  assign is_write     = bus.mem_write;
  assign victim_dirty = lru_out ? dirty1_out : dirty0_out;
  assign victim_line  = {pmem_tag, bus.mem_address[6:4]};
  assign req_line     = bus.mem_address[15:4];
  assign ld_from_vic  = 1'b0;

  // A request dropped mid-miss lets the pmem transfer finish, then parks in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:      if (req) state <= CHECK;
        CHECK: begin
          if (!req || hit)       state <= IDLE;
          else if (victim_dirty) state <= WRITEBACK;
          else                   state <= ALLOCATE;
        end
        WRITEBACK: if (bus.pmem_resp) state <= req ? ALLOCATE : IDLE;
        ALLOCATE:  if (bus.pmem_resp) state <= req ? CHECK : IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_address  = '0;
    ld_cache          = 1'b0;
    ld_lru            = 1'b0;
    ld_dirty0         = 1'b0;
    ld_dirty1         = 1'b0;
    dirty0_in         = 1'b0;
    dirty1_in         = 1'b0;
    writecachemux_sel = 1'b0;
    data0mux_sel      = 1'b0;
    data1mux_sel      = 1'b0;
    case (state)
      CHECK: begin
        if (req && hit) begin
          bus.mem_resp = 1'b1;
          ld_lru       = 1'b1;
          if (is_write) begin
            writecachemux_sel = 1'b1;
            if (curr_way) begin
              data1mux_sel = 1'b1;
              ld_dirty1    = 1'b1;
              dirty1_in    = 1'b1;
            end else begin
              data0mux_sel = 1'b1;
              ld_dirty0    = 1'b1;
              dirty0_in    = 1'b1;
            end
          end
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = line_to_addr(victim_line);
        if (bus.pmem_resp) begin
          ld_dirty0 = ~lru_out;
          ld_dirty1 = lru_out;
        end
      end
      ALLOCATE: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = line_to_addr(req_line);
        if (bus.pmem_resp) begin
          ld_cache  = 1'b1;
          ld_dirty0 = ~lru_out;
          ld_dirty1 = lru_out;
        end
      end
      default: ;
    endcase
  end

`ifdef D_CACHE_PERF_CNT_EN
  logic hit_evt, miss_evt, wb_evt;

  assign hit_evt  = (state == CHECK) && req && hit;
  assign miss_evt = (state == CHECK) && req && !hit;
  assign wb_evt   = (state == WRITEBACK) && bus.pmem_resp;

  d_cache_perf_counters #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .perf_clr   (perf_clr),
    .hit_evt    (hit_evt),
    .miss_evt   (miss_evt),
    .wb_evt     (wb_evt),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );
`endif

endmodule

// File: tb/tb_d_cache_control.sv
// Directed bench for d_cache_control; counter checks are built only with D_CACHE_PERF_CNT_EN.
module tb_d_cache_control;
  import d_cache_control_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  d_cache_control_if bus ();

  logic       hit, curr_way, lru_out, dirty0_out, dirty1_out;
  logic [8:0] pmem_tag;
  logic       ld_cache, ld_lru, ld_dirty0, ld_dirty1, dirty0_in, dirty1_in;
  logic       writecachemux_sel, data0mux_sel, data1mux_sel, ld_from_vic;

  int tests_run = 0;
  int tests_failed = 0;
  logic pw_seen;

`ifdef D_CACHE_PERF_CNT_EN
  logic        perf_clr;
  logic [15:0] hit_count, miss_count, wb_count;
`endif

  d_cache_control dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .hit               (hit),
    .curr_way          (curr_way),
    .lru_out           (lru_out),
    .dirty0_out        (dirty0_out),
    .dirty1_out        (dirty1_out),
    .pmem_tag          (pmem_tag),
    .ld_cache          (ld_cache),
    .ld_lru            (ld_lru),
    .ld_dirty0         (ld_dirty0),
    .ld_dirty1         (ld_dirty1),
    .dirty0_in         (dirty0_in),
    .dirty1_in         (dirty1_in),
    .writecachemux_sel (writecachemux_sel),
    .data0mux_sel      (data0mux_sel),
    .data1mux_sel      (data1mux_sel),
    .ld_from_vic       (ld_from_vic)
`ifdef D_CACHE_PERF_CNT_EN
    ,
    .perf_clr          (perf_clr),
    .hit_count         (hit_count),
    .miss_count        (miss_count),
    .wb_count          (wb_count)
`endif
  );

`ifdef D_CACHE_PERF_CNT_EN
  d_cache_control_if bus2 ();
  logic       hit2, perf_clr2;
  logic [8:0] tag2;
  logic       b_ld_cache, b_ld_lru, b_ld_dirty0, b_ld_dirty1, b_dirty0_in, b_dirty1_in;
  logic       b_wcm, b_d0, b_d1, b_vic;
  logic [1:0] hit_count2, miss_count2, wb_count2;

  d_cache_control #(.CNT_WIDTH(2)) dut2 (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus2),
    .hit               (hit2),
    .curr_way          (1'b0),
    .lru_out           (1'b0),
    .dirty0_out        (1'b0),
    .dirty1_out        (1'b0),
    .pmem_tag          (tag2),
    .ld_cache          (b_ld_cache),
    .ld_lru            (b_ld_lru),
    .ld_dirty0         (b_ld_dirty0),
    .ld_dirty1         (b_ld_dirty1),
    .dirty0_in         (b_dirty0_in),
    .dirty1_in         (b_dirty1_in),
    .writecachemux_sel (b_wcm),
    .data0mux_sel      (b_d0),
    .data1mux_sel      (b_d1),
    .ld_from_vic       (b_vic),
    .perf_clr          (perf_clr2),
    .hit_count         (hit_count2),
    .miss_count        (miss_count2),
    .wb_count          (wb_count2)
  );
`endif

  // {mem_resp, ld_cache, ld_lru, ld_dirty0, ld_dirty1, dirty0_in, dirty1_in,
  //  writecachemux_sel, data0mux_sel, data1mux_sel, ld_from_vic, pmem_read, pmem_write}
  wire [12:0] outs = {bus.mem_resp, ld_cache, ld_lru, ld_dirty0, ld_dirty1, dirty0_in, dirty1_in,
                      writecachemux_sel, data0mux_sel, data1mux_sel, ld_from_vic,
                      bus.pmem_read, bus.pmem_write};

  always @(negedge clk) if (bus.pmem_write === 1'b1) pw_seen <= 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_address = 16'h0; bus.pmem_resp = 0;
    hit = 0; curr_way = 0; lru_out = 0; dirty0_out = 0; dirty1_out = 0; pmem_tag = 9'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
`ifdef D_CACHE_PERF_CNT_EN
    perf_clr = 0;
    bus2.mem_read = 0; bus2.mem_write = 0; bus2.mem_address = 16'h0; bus2.pmem_resp = 0;
    hit2 = 0; perf_clr2 = 0; tag2 = 9'h0;
`endif
    rst_n = 0;
    #12;
    tests_run++;
    if (outs !== 13'h0 || bus.pmem_address !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: outs=%b addr=%h expected all 0", outs, bus.pmem_address);
    end
    step();
    rst_n = 1;
    sample();
    tests_run++;
    if (outs !== 13'h0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: outs=%b expected 0", outs);
    end
  endtask

  task automatic test_read_hit();
    step();
    bus.mem_read = 1; bus.mem_address = 16'h2AA0; hit = 1; curr_way = 0;
    sample();
    tests_run++;
    if (bus.mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_hit_cycle1: mem_resp=%b expected 0", bus.mem_resp);
    end
    step();
    sample();
    tests_run++;
    if (outs !== 13'b1_0_1_0_0_0_0_0_0_0_0_0_0 || bus.pmem_address !== 16'h0) begin
      tests_failed++;
      $display("FAIL read_hit_cycle2: outs=%b addr=%h expected outs=1010000000000 addr=0000", outs, bus.pmem_address);
    end
    step();
    bus.mem_read = 0; hit = 0;
    sample();
    tests_run++;
    if (outs !== 13'h0) begin
      tests_failed++;
      $display("FAIL read_hit_return_idle: outs=%b expected 0", outs);
    end
  endtask

  task automatic test_write_hit();
    step();
    bus.mem_write = 1; bus.mem_address = 16'h1234; hit = 1; curr_way = 1;
    step();
    sample();
    tests_run++;
    if (outs !== 13'b1_0_1_0_1_0_1_1_0_1_0_0_0) begin
      tests_failed++;
      $display("FAIL write_hit_way1: outs=%b expected 1010101101000", outs);
    end
    step();
    bus.mem_write = 0; hit = 0; curr_way = 0;
    sample();
  endtask

  task automatic test_clean_miss();
    bit stayed;
    step();
    pw_seen = 0;
    lru_out = 0; dirty0_out = 0; hit = 0;
    bus.mem_read = 1; bus.mem_address = 16'h1230;
    step();
    sample();
    tests_run++;
    if (outs !== 13'h0) begin
      tests_failed++;
      $display("FAIL clean_miss_check: outs=%b expected 0", outs);
    end
    step();
    sample();
    tests_run++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h1230 || writecachemux_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL clean_miss_alloc: pmem_read=%b addr=%h wcm=%b expected 1 1230 0",
               bus.pmem_read, bus.pmem_address, writecachemux_sel);
    end
    stayed = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      sample();
      if (bus.pmem_read !== 1'b1 || ld_cache !== 1'b0) stayed = 0;
    end
    tests_run++;
    if (!stayed) begin
      tests_failed++;
      $display("FAIL clean_miss_hold: pmem_read not held / early ld_cache, got 0 expected 1");
    end
    step();
    bus.pmem_resp = 1;
    sample();
    tests_run++;
    if (outs !== 13'b0_1_0_1_0_0_0_0_0_0_0_1_0) begin
      tests_failed++;
      $display("FAIL clean_miss_fill: outs=%b expected 0101000000010", outs);
    end
    step();
    bus.pmem_resp = 0; hit = 1;
    sample();
    tests_run++;
    if (outs !== 13'b1_0_1_0_0_0_0_0_0_0_0_0_0) begin
      tests_failed++;
      $display("FAIL clean_miss_resp: outs=%b expected 1010000000000", outs);
    end
    step();
    bus.mem_read = 0; hit = 0;
    sample();
    tests_run++;
    if (pw_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL clean_miss_no_wb: pmem_write seen=%b expected 0", pw_seen);
    end
  endtask

  task automatic test_dirty_miss();
    step();
    lru_out = 1; dirty1_out = 1; dirty0_out = 0; pmem_tag = 9'h1FF; hit = 0;
    bus.mem_read = 1; bus.mem_address = 16'h4AB0;
    step();
    step();
    sample();
    tests_run++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_address !== 16'hFFB0) begin
      tests_failed++;
      $display("FAIL dirty_miss_wb: pw=%b pr=%b addr=%h expected 1 0 ffb0",
               bus.pmem_write, bus.pmem_read, bus.pmem_address);
    end
    step();
    step();
    bus.pmem_resp = 1;
    sample();
    tests_run++;
    if (outs !== 13'b0_0_0_0_1_0_0_0_0_0_0_0_1) begin
      tests_failed++;
      $display("FAIL dirty_miss_wb_done: outs=%b expected 0000100000001", outs);
    end
    step();
    bus.pmem_resp = 0; dirty1_out = 0;
    sample();
    tests_run++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 16'h4AB0) begin
      tests_failed++;
      $display("FAIL dirty_miss_alloc: pr=%b pw=%b addr=%h expected 1 0 4ab0",
               bus.pmem_read, bus.pmem_write, bus.pmem_address);
    end
    step();
    bus.pmem_resp = 1;
    sample();
    tests_run++;
    if (outs !== 13'b0_1_0_0_1_0_0_0_0_0_0_1_0) begin
      tests_failed++;
      $display("FAIL dirty_miss_fill: outs=%b expected 0100100000010", outs);
    end
    step();
    bus.pmem_resp = 0; hit = 1;
    sample();
    tests_run++;
    if (bus.mem_resp !== 1'b1) begin
      tests_failed++;
      $display("FAIL dirty_miss_resp: mem_resp=%b expected 1", bus.mem_resp);
    end
    step();
    idle_inputs();
    sample();
  endtask

  task automatic test_perf_counts();
`ifdef D_CACHE_PERF_CNT_EN
    tests_run++;
    if (hit_count !== 16'd4 || miss_count !== 16'd2 || wb_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL perf_counts: hit=%0d miss=%0d wb=%0d expected 4 2 1", hit_count, miss_count, wb_count);
    end
`endif
  endtask

  task automatic test_read_write_both();
    step();
    bus.mem_read = 1; bus.mem_write = 1; bus.mem_address = 16'h0100; hit = 1; curr_way = 0;
    step();
    sample();
    tests_run++;
    if (outs !== 13'b1_0_1_1_0_1_0_1_1_0_0_0_0) begin
      tests_failed++;
      $display("FAIL rw_both_is_write: outs=%b expected 1011010110000", outs);
    end
    step();
    idle_inputs();
    sample();
  endtask

  task automatic test_drop_mid_miss();
    step();
    bus.mem_read = 1; bus.mem_address = 16'h0560; lru_out = 0; dirty0_out = 0; hit = 0;
    step();
    step();
    bus.mem_read = 0;
    sample();
    tests_run++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h0560) begin
      tests_failed++;
      $display("FAIL drop_alloc_held: pr=%b addr=%h expected 1 0560", bus.pmem_read, bus.pmem_address);
    end
    step();
    bus.pmem_resp = 1;
    sample();
    tests_run++;
    if (ld_cache !== 1'b1 || ld_dirty0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_still_fills: ld_cache=%b ld_dirty0=%b expected 1 1", ld_cache, ld_dirty0);
    end
    step();
    bus.pmem_resp = 0; hit = 1;
    sample();
    tests_run++;
    if (outs !== 13'h0) begin
      tests_failed++;
      $display("FAIL drop_returns_idle: outs=%b expected 0", outs);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_pmem_resp_ignored();
    step();
    bus.pmem_resp = 1;
    step();
    sample();
    tests_run++;
    if (outs !== 13'h0) begin
      tests_failed++;
      $display("FAIL stray_pmem_resp: outs=%b expected 0", outs);
    end
    step();
    bus.pmem_resp = 0; bus.mem_read = 1; bus.mem_address = 16'h2AA0; hit = 1;
    step();
    sample();
    tests_run++;
    if (bus.mem_resp !== 1'b1) begin
      tests_failed++;
      $display("FAIL stray_then_hit: mem_resp=%b expected 1", bus.mem_resp);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_perf_clr();
`ifdef D_CACHE_PERF_CNT_EN
    step();
    bus.mem_read = 1; bus.mem_address = 16'h2AA0; hit = 1;
    step();
    perf_clr = 1;
    step();
    perf_clr = 0;
    idle_inputs();
    sample();
    tests_run++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0 || wb_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL perf_clr: hit=%0d miss=%0d wb=%0d expected 0 0 0", hit_count, miss_count, wb_count);
    end
`endif
  endtask

  task automatic test_reset_during_wb();
    step();
    lru_out = 1; dirty1_out = 1; pmem_tag = 9'h0AA; hit = 0;
    bus.mem_write = 1; bus.mem_address = 16'h0070;
    step();
    step();
    sample();
    tests_run++;
    if (bus.pmem_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_wb_entered: pmem_write=%b expected 1", bus.pmem_write);
    end
    #2;
    rst_n = 0;
    #1;
    tests_run++;
    if (outs !== 13'h0 || bus.pmem_address !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_async_clear: outs=%b addr=%h expected 0", outs, bus.pmem_address);
    end
    idle_inputs();
    step();
    step();
    rst_n = 1;
    step();
    sample();
    tests_run++;
    if (outs !== 13'h0 || bus.pmem_address !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_release_idle: outs=%b addr=%h expected 0", outs, bus.pmem_address);
    end
  endtask

  task automatic test_perf_saturate();
`ifdef D_CACHE_PERF_CNT_EN
    step();
    bus2.mem_read = 1; bus2.mem_address = 16'h2AA0; hit2 = 1;
    for (int i = 0; i < 12; i++) step();
    bus2.mem_read = 0; hit2 = 0;
    step();
    sample();
    tests_run++;
    if (hit_count2 !== 2'd3 || miss_count2 !== 2'd0) begin
      tests_failed++;
      $display("FAIL perf_saturate: hit=%0d miss=%0d expected 3 0", hit_count2, miss_count2);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_perf_counts();
    test_read_write_both();
    test_drop_mid_miss();
    test_pmem_resp_ignored();
    test_perf_clr();
    test_reset_during_wb();
    test_perf_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
